// File: rtl/heichips25_req_scheduler.sv
// Round-robin scheduler that puts Snitch fetch and LSU requests onto one serialized memory
// channel, tracks outstanding requests in issue order, and routes each response to its issuer.
module heichips25_req_scheduler #(
    parameter int MaxOutstanding = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 inst_valid_i,
    input  logic [7:0]                           inst_addr_i,
    output logic                                 inst_gnt_o,
    input  logic                                 data_valid_i,
    input  logic [7:0]                           data_addr_i,
    input  logic [31:0]                          data_wdata_i,
    input  logic                                 data_write_i,
    input  logic [3:0]                           data_strb_i,
    output logic                                 data_gnt_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [7:0]                           out_addr_o,
    output logic [31:0]                          out_wdata_o,
    output logic                                 out_write_o,
    output logic [3:0]                           out_strb_o,
    input  logic                                 rsp_valid_i,
    input  logic [31:0]                          rsp_data_i,
    output logic                                 rsp_ready_o,
    output logic                                 inst_rsp_valid_o,
    output logic [31:0]                          inst_rsp_data_o,
    output logic                                 data_rsp_valid_o,
    output logic [31:0]                          data_rsp_data_o,
    input  logic                                 data_rsp_ready_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 err_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    typedef enum logic {
        TagInst = 1'b0,
        TagData = 1'b1
    } tag_e;

    logic [CntW-1:0] count;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    tag_e            tags [MaxOutstanding];
    logic            favour_data;
    logic            err_q;

    logic slot_free;
    logic capture;
    logic pick_data;
    logic fifo_empty;
    logic pop;
    tag_e head;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Credit check uses the registered count, so a same-cycle pop never frees a slot early.
    assign slot_free  = !out_valid_o || out_ready_i;
    assign capture    = slot_free && (count < CntMax) && (inst_valid_i || data_valid_i);
    assign pick_data  = data_valid_i && (!inst_valid_i || favour_data);
    assign inst_gnt_o = capture && !pick_data;
    assign data_gnt_o = capture && pick_data;

    assign fifo_empty = (count == '0);
    assign head       = tags[rd_ptr];
    assign pop        = rsp_valid_i && rsp_ready_o && !fifo_empty;

    assign inst_rsp_data_o = rsp_data_i;
    assign data_rsp_data_o = rsp_data_i;
    assign outstanding_o   = count;
    assign err_o           = err_q;

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        rsp_ready_o      = 1'b0;
        inst_rsp_valid_o = 1'b0;
        data_rsp_valid_o = 1'b0;
        if (fifo_empty) begin
            rsp_ready_o = rsp_valid_i;
        end else if (head == TagInst) begin
            inst_rsp_valid_o = rsp_valid_i;
            rsp_ready_o      = rsp_valid_i;
        end else begin
            data_rsp_valid_o = rsp_valid_i;
            rsp_ready_o      = data_rsp_ready_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            out_addr_o  <= '0;
            out_wdata_o <= '0;
            out_write_o <= 1'b0;
            out_strb_o  <= '0;
            favour_data <= 1'b0;
        end else if (capture) begin
            out_valid_o <= 1'b1;
            favour_data <= !pick_data;
            if (pick_data) begin
                out_addr_o  <= data_addr_i;
                out_wdata_o <= data_wdata_i;
                out_write_o <= data_write_i;
                out_strb_o  <= data_strb_i;
            end else begin
                out_addr_o  <= inst_addr_i;
                out_wdata_o <= '0;
                out_write_o <= 1'b0;
                out_strb_o  <= '0;
            end
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // NOTE: the tag array is tiny, so it is reset with the pointers to keep the head defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                tags[i] <= TagInst;
            end
        end else begin
            if (capture) begin
                tags[wr_ptr] <= pick_data ? TagData : TagInst;
                wr_ptr       <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({capture, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rsp_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_heichips25_req_scheduler.sv
// Self-checking bench for heichips25_req_scheduler: directed scenarios plus random traffic,
// compared every cycle against a queue-based transaction model.
module tb_heichips25_req_scheduler;

    localparam int MAX = 2;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inst_valid_i = 1'b0;
    logic [7:0]    inst_addr_i = '0;
    logic          inst_gnt_o;
    logic          data_valid_i = 1'b0;
    logic [7:0]    data_addr_i = '0;
    logic [31:0]   data_wdata_i = '0;
    logic          data_write_i = 1'b0;
    logic [3:0]    data_strb_i = '0;
    logic          data_gnt_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [7:0]    out_addr_o;
    logic [31:0]   out_wdata_o;
    logic          out_write_o;
    logic [3:0]    out_strb_o;
    logic          rsp_valid_i = 1'b0;
    logic [31:0]   rsp_data_i = '0;
    logic          rsp_ready_o;
    logic          inst_rsp_valid_o;
    logic [31:0]   inst_rsp_data_o;
    logic          data_rsp_valid_o;
    logic [31:0]   data_rsp_data_o;
    logic          data_rsp_ready_i = 1'b0;
    logic [CW-1:0] outstanding_o;
    logic          err_o;

    heichips25_req_scheduler #(.MaxOutstanding(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
        .data_valid_i(data_valid_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_write_i(data_write_i), .data_strb_i(data_strb_i), .data_gnt_o(data_gnt_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_addr_o(out_addr_o),
        .out_wdata_o(out_wdata_o), .out_write_o(out_write_o), .out_strb_o(out_strb_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_ready_o(rsp_ready_o),
        .inst_rsp_valid_o(inst_rsp_valid_o), .inst_rsp_data_o(inst_rsp_data_o),
        .data_rsp_valid_o(data_rsp_valid_o), .data_rsp_data_o(data_rsp_data_o),
        .data_rsp_ready_i(data_rsp_ready_i), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction model: issue-order queue of requesters (0 = fetch, 1 = LSU).
    bit          q_tags[$];
    bit          fav_data;
    bit          m_out_v;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    bit          m_write;
    logic [3:0]  m_strb;
    bit          m_err;

    bit e_inst_gnt, e_data_gnt, e_rsp_ready, e_inst_rsp, e_data_rsp, e_pop, e_stray;

    task automatic model_reset();
        q_tags.delete();
        fav_data = 0; m_out_v = 0; m_addr = '0; m_wdata = '0; m_write = 0; m_strb = '0; m_err = 0;
    endtask

    task automatic model_eval();
        bit granted;
        bit winner_data;
        granted = (!m_out_v || out_ready_i) && (q_tags.size() < MAX) && (inst_valid_i || data_valid_i);
        if (inst_valid_i && data_valid_i) winner_data = fav_data;
        else                              winner_data = data_valid_i;
        e_inst_gnt = granted && !winner_data;
        e_data_gnt = granted && winner_data;
        e_rsp_ready = 0; e_inst_rsp = 0; e_data_rsp = 0; e_pop = 0; e_stray = 0;
        if (rsp_valid_i) begin
            if (q_tags.size() == 0) begin
                e_rsp_ready = 1; e_stray = 1;
            end else if (q_tags[0] == 0) begin
                e_inst_rsp = 1; e_rsp_ready = 1; e_pop = 1;
            end else begin
                e_data_rsp = 1; e_rsp_ready = data_rsp_ready_i; e_pop = data_rsp_ready_i;
            end
        end else if (q_tags.size() != 0 && q_tags[0] == 1) begin
            e_rsp_ready = data_rsp_ready_i;
        end
    endtask

    task automatic model_check();
        check("inst_gnt", 32'(inst_gnt_o), 32'(e_inst_gnt));
        check("data_gnt", 32'(data_gnt_o), 32'(e_data_gnt));
        check("out_valid", 32'(out_valid_o), 32'(m_out_v));
        check("out_addr", 32'(out_addr_o), 32'(m_addr));
        check("out_wdata", out_wdata_o, m_wdata);
        check("out_write", 32'(out_write_o), 32'(m_write));
        check("out_strb", 32'(out_strb_o), 32'(m_strb));
        check("rsp_ready", 32'(rsp_ready_o), 32'(e_rsp_ready));
        check("inst_rsp_valid", 32'(inst_rsp_valid_o), 32'(e_inst_rsp));
        check("data_rsp_valid", 32'(data_rsp_valid_o), 32'(e_data_rsp));
        check("inst_rsp_data", inst_rsp_data_o, rsp_data_i);
        check("data_rsp_data", data_rsp_data_o, rsp_data_i);
        check("outstanding", 32'(outstanding_o), 32'(q_tags.size()));
        check("err", 32'(err_o), 32'(m_err));
    endtask

    task automatic model_update();
        if (e_inst_gnt || e_data_gnt) begin
            q_tags.push_back(e_data_gnt);
            m_out_v  = 1;
            fav_data = e_inst_gnt;
            if (e_data_gnt) begin
                m_addr = data_addr_i; m_wdata = data_wdata_i; m_write = data_write_i; m_strb = data_strb_i;
            end else begin
                m_addr = inst_addr_i; m_wdata = '0; m_write = 0; m_strb = '0;
            end
        end else if (out_ready_i) begin
            m_out_v = 0;
        end
        if (e_pop) void'(q_tags.pop_front());
        if (e_stray) m_err = 1;
    endtask

    // Called at posedge+1: let inputs settle, check, then advance one clock.
    task automatic settle();
        #3;
        model_eval();
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        inst_valid_i = 0; data_valid_i = 0; rsp_valid_i = 0; data_rsp_ready_i = 0;
        out_ready_i = 1; data_write_i = 0; data_strb_i = '0; data_wdata_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        model_reset();
        check("reset_err_clear", 32'(err_o), 32'd0);
        check("reset_outstanding", 32'(outstanding_o), 32'd0);
        model_eval();
        model_check();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        inst_valid_i = 0; data_valid_i = 0; data_rsp_ready_i = 1; out_ready_i = 1;
        while (q_tags.size() != 0 && budget > 0) begin
            rsp_valid_i = 1;
            rsp_data_i  = $urandom;
            cycle();
            budget--;
        end
        rsp_valid_i = 0;
        check("drain_budget", 32'(q_tags.size()), 32'd0);
    endtask

    bit order[$];
    int gnt_count;
    logic [7:0] held_addr;

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single fetch.
        inst_valid_i = 1; inst_addr_i = 8'h10;
        settle();
        check("fetch_gnt", 32'(inst_gnt_o), 32'd1);
        advance();
        inst_valid_i = 0;
        settle();
        check("fetch_addr", 32'(out_addr_o), 32'h10);
        check("fetch_write", 32'(out_write_o), 32'd0);
        check("fetch_outstanding", 32'(outstanding_o), 32'd1);
        advance();
        rsp_valid_i = 1; rsp_data_i = 32'hDEADBEEF;
        settle();
        check("fetch_rsp_valid", 32'(inst_rsp_valid_o), 32'd1);
        check("fetch_rsp_data", inst_rsp_data_o, 32'hDEADBEEF);
        advance();
        rsp_valid_i = 0;
        settle();
        check("fetch_rsp_once", 32'(inst_rsp_valid_o), 32'd0);
        check("fetch_done_outstanding", 32'(outstanding_o), 32'd0);
        advance();

        // Contention with immediate responses.
        do_reset();
        inst_valid_i = 1; data_valid_i = 1; data_rsp_ready_i = 1;
        order.delete();
        for (int i = 0; i < 6; i++) begin
            rsp_valid_i = (q_tags.size() != 0);
            rsp_data_i  = $urandom;
            settle();
            if (inst_gnt_o) order.push_back(1'b0);
            if (data_gnt_o) order.push_back(1'b1);
            advance();
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("contention_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'd2, 32'(i % 2));
        drain();

        // Credit limit, no responses.
        do_reset();
        inst_valid_i = 1; data_valid_i = 1;
        gnt_count = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            gnt_count += int'(inst_gnt_o) + int'(data_gnt_o);
            advance();
        end
        check("credit_captures", 32'(gnt_count), 32'd2);
        check("credit_outstanding", 32'(outstanding_o), 32'd2);
        rsp_valid_i = 1; rsp_data_i = 32'h1234_5678;
        settle();
        check("credit_refused_on_pop", 32'(inst_gnt_o | data_gnt_o), 32'd0);
        advance();
        rsp_valid_i = 0;
        settle();
        check("credit_third_capture", 32'(inst_gnt_o | data_gnt_o), 32'd1);
        advance();
        drain();

        // LSU write with response backpressure.
        do_reset();
        data_valid_i = 1; data_addr_i = 8'h20; data_wdata_i = 32'h55AA00FF; data_write_i = 1; data_strb_i = 4'hF;
        settle();
        check("lsu_gnt", 32'(data_gnt_o), 32'd1);
        advance();
        data_valid_i = 0;
        settle();
        check("lsu_wdata", out_wdata_o, 32'h55AA00FF);
        check("lsu_strb", 32'(out_strb_o), 32'hF);
        advance();
        rsp_valid_i = 1; rsp_data_i = 32'hA5A5_0001; data_rsp_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("lsu_bp_rsp_ready", 32'(rsp_ready_o), 32'd0);
            check("lsu_bp_rsp_valid", 32'(data_rsp_valid_o), 32'd1);
            advance();
        end
        data_rsp_ready_i = 1;
        settle();
        check("lsu_pop_ready", 32'(rsp_ready_o), 32'd1);
        advance();
        rsp_valid_i = 0;
        settle();
        check("lsu_popped", 32'(outstanding_o), 32'd0);
        advance();

        // Stray response, sticky error until reset.
        rsp_valid_i = 1; rsp_data_i = 32'hBAD0_0BAD; data_rsp_ready_i = 0;
        settle();
        check("stray_ready", 32'(rsp_ready_o), 32'd1);
        check("stray_no_valid", 32'(inst_rsp_valid_o | data_rsp_valid_o), 32'd0);
        advance();
        rsp_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stray_err_sticky", 32'(err_o), 32'd1);
            advance();
        end
        do_reset();

        // Output stall with both requesters valid.
        inst_valid_i = 1; inst_addr_i = 8'h31; data_valid_i = 1; data_addr_i = 8'h42;
        data_write_i = 0; out_ready_i = 0;
        cycle();
        held_addr = out_addr_o;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_no_gnt", 32'(inst_gnt_o | data_gnt_o), 32'd0);
            check("stall_addr_stable", 32'(out_addr_o), 32'h31);
            advance();
        end
        check("stall_held_addr", 32'(held_addr), 32'h31);
        out_ready_i = 1;
        settle();
        check("stall_release_data", 32'(data_gnt_o), 32'd1);
        advance();
        drain();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            inst_valid_i     = ($urandom % 3) != 0;
            inst_addr_i      = 8'($urandom);
            data_valid_i     = ($urandom % 2) != 0;
            data_addr_i      = 8'($urandom);
            data_wdata_i     = $urandom;
            data_write_i     = ($urandom % 2) != 0;
            data_strb_i      = 4'($urandom);
            out_ready_i      = ($urandom % 4) != 0;
            rsp_valid_i      = (q_tags.size() != 0) && (($urandom % 2) != 0);
            rsp_data_i       = $urandom;
            data_rsp_ready_i = ($urandom % 3) != 0;
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
